dual_issue_dispatch: RTL and testbench
======================================

# dual_issue_dispatch

Dispatch stage for the dual-issue RV32 core. It accepts an in-order instruction pair from fetch and classifies each instruction. It steers memory/control instructions to datapath-1 (common) and ALU-only instructions to datapath-2, splitting the pair over two cycles when both need datapath-1. It owns the D-stage pipeline registers of both datapaths and produces the `order_change_d`, `rdd` and `rdd_2` values that the hazard unit consumes.

## Interface
- No parameters. Widths are fixed at RV32.
- `clk` in 1: single core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_valid` in 1: the fetch pair is valid.
- `fetch_ready` out 1: the pair is consumed at this edge.
- `instr0_f` in 32: older instruction of the pair.
- `instr1_f` in 32: younger instruction of the pair.
- `pc0_f` in 32: PC of `instr0_f`; the PC of `instr1_f` is `pc0_f + 4`, modulo 2^32.
- `stall_d` in 1: hold the D registers and FSM; OR of the hazard unit's D-stage stalls.
- `flush_d` in 1: kill D-stage contents; OR of the hazard unit's D-stage flushes.
- `instr_d` out 32: D-register instruction, datapath-1.
- `pc_d` out 32: D-register PC, datapath-1.
- `valid_d` out 1: datapath-1 D slot holds a real instruction.
- `instr_d_2` out 32: D-register instruction, datapath-2.
- `pc_d_2` out 32: D-register PC, datapath-2.
- `valid_d_2` out 1: datapath-2 D slot holds a real instruction.
- `order_change_d` out 1: 1 means the datapath-2 slot holds the older instruction.
- `rdd` out 5: `instr_d[11:7]`; 0 when `valid_d`=0.
- `rdd_2` out 5: `instr_d_2[11:7]`; 0 when `valid_d_2`=0.

## Operation
- **Classification** (combinational, per instruction):
  - ALU class: opcodes 0110011, 0010011, 0110111, 0010111.
  - COMMON class: everything else, including load, store, branch, jal, jalr, system and illegal opcodes.
- **Steering in state PAIR**, with older instruction O and younger instruction Y:
  - O and Y both ALU: O to DP1, Y to DP2, `order_change_d`=0.
  - O COMMON, Y ALU: O to DP1, Y to DP2, `order_change_d`=0.
  - O ALU, Y COMMON: swap; Y to DP1, O to DP2, `order_change_d`=1.
  - O and Y both COMMON: split. O to DP1, DP2 slot empty (`valid_d_2`=0), `fetch_ready`=0, FSM moves to HOLD.
- **State HOLD**: Y goes to DP1 alone, `order_change_d`=0, `fetch_ready`=1, FSM returns to PAIR.
- **Empty slots**: an empty slot loads NOP (0x00000013), PC 0 and valid 0.
- **No fetch input**: `fetch_valid`=0 in PAIR loads bubbles into both slots.
- **`fetch_ready`** = !rst & !flush_d & !stall_d & fetch_valid & (state==HOLD | no split required).
- **Priority at each edge**: rst > flush_d > stall_d > normal update.
  - flush_d: both slots are loaded with bubbles, `order_change_d`=0, FSM goes to PAIR, the held younger instruction is discarded, and the pair is not consumed.
  - stall_d: all D registers and the FSM hold their values; `fetch_ready`=0.
- **Reset values**:
  - instr_d and instr_d_2 = NOP.
  - pc_d and pc_d_2 = 0.
  - valid_d, valid_d_2 and order_change_d = 0.
  - rdd and rdd_2 = 0.
  - FSM = PAIR.
- **Fetch stability**: fetch holds `instr0_f`/`instr1_f`/`pc0_f` stable while `fetch_valid`=1 and `fetch_ready`=0. The HOLD cycle therefore reads Y directly from fetch; no copy is stored.
- **Control instructions**: a branch or jump in O does not suppress Y. Wrong-path removal is done by `flush_d`.

## Timing
- D outputs are registered. The pair presented in cycle n appears in the D outputs after edge n.
- A split pair takes 2 cycles, with D contents O then Y. Only the second cycle asserts `fetch_ready`.
- `rdd` and `rdd_2` are derived combinationally from the registers, so they have zero added latency.
- Throughput is 2 instructions per cycle for non-split pairs and 1 per cycle for split pairs.
- Simultaneous events:
  - stall_d during HOLD: remain in HOLD.
  - flush_d with stall_d: flush wins.
  - rst during HOLD: go to PAIR with the reset values.

## Configuration
- `PAIR_RAW_SPLIT_EN` defined: the block also splits the pair when Y reads O's rd. "Reads" means Y's rs1 or rs2 equals O's rd, that rd is non-zero, and O writes a register (not store or branch). The split uses the same PAIR→HOLD sequence, with O placed in its class-correct slot, so the hazard unit's parallel interlock never fires.
- `PAIR_RAW_SPLIT_EN` undefined: the block ignores intra-pair RAW dependencies and the hazard unit resolves them through its parallel stall/flush outputs.

## Structure
- Shared package `dispatch_pkg`:
  - opcode localparams;
  - `NOP_INSTR`;
  - `instr_class_t` enum (ALU, COMMON);
  - `dispatch_state_t` enum (PAIR, HOLD);
  - `d_slot_t` struct (instr, pc, valid).
- Sub-module `instr_classifier`: combinational. Maps a 32-bit instruction to class, rd, rs1, rs2 and a writes-rd flag. It is instantiated twice.

## Test plan
- **ALU pair, no swap**: O=addi x1,x0,5 @0x100, Y=add x2,x3,x4 → next cycle instr_d=O, pc_d=0x100, instr_d_2=Y, pc_d_2=0x104, order_change_d=0, rdd=1, rdd_2=2, fetch_ready=1.
- **Swap**: O=add x5,x6,x7, Y=lw x8,0(x9) → instr_d=lw, pc_d=pc0+4, instr_d_2=add, order_change_d=1.
- **Split, both COMMON**: O=lw x1, Y=sw x2 → cycle 1: DP1=lw, valid_d_2=0, fetch_ready=0; cycle 2: DP1=sw, fetch_ready=1.
- **Stall and flush in HOLD**: split pair, stall_d high 3 cycles in HOLD → outputs frozen, fetch_ready=0. Then flush_d → both valids 0, state PAIR, pair not consumed.
- **PC wrap and reset**: pc0_f=0xFFFFFFFC → pc1 = 0x00000000. Also assert rst mid-HOLD → all outputs at reset values next cycle.
- **RAW pair**: O=addi x3,x0,1, Y=add x4,x3,x3.
  - With `PAIR_RAW_SPLIT_EN`: split over 2 cycles.
  - Without it: single-cycle pair with rdd=3.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared definitions for the dual-issue dispatch stage.
// Contents: opcode constants used for classification, the NOP encoding,
// instruction class and dispatch FSM enums, the D-slot record, and a
// helper that builds an empty (bubble) slot.
package dispatch_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ALU    = 1'b0,
        COMMON = 1'b1
    } instr_class_t;

    typedef enum logic {
        PAIR = 1'b0,
        HOLD = 1'b1
    } dispatch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } d_slot_t;

    function automatic d_slot_t bubble_slot();
        d_slot_t s;
        s.instr = NOP_INSTR;
        s.pc    = 32'h0;
        s.valid = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/dual_issue_dispatch_if.sv
// Fetch-to-dispatch pair handshake.
// Handshake: a pair transfers on a rising clk edge where fetch_valid and
// fetch_ready are both 1. While fetch_valid=1 and fetch_ready=0, fetch must
// hold instr0_f/instr1_f/pc0_f stable. fetch_ready may depend
// combinationally on fetch_valid and the pair contents.
// Signals: fetch_valid, fetch_ready, instr0_f (older), instr1_f (younger),
// pc0_f (PC of instr0_f; younger is pc0_f+4).
// Modports: master = fetch side, slave = dispatch side.
interface dual_issue_dispatch_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] instr0_f;
    logic [31:0] instr1_f;
    logic [31:0] pc0_f;

    modport master (
        output fetch_valid, instr0_f, instr1_f, pc0_f,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid, instr0_f, instr1_f, pc0_f,
        output fetch_ready
    );
endinterface

// File: rtl/dual_issue_dispatch_classifier.sv
// instr_classifier: combinational decode of one RV32 instruction.
// Ports: instr (in 32), cls (ALU/COMMON), rd/rs1/rs2 (raw register fields),
// writes_rd (1 unless the opcode is store or branch).
module instr_classifier
    import dispatch_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output logic [4:0]   rd,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic         writes_rd
);
    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign rd          = instr[11:7];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    always_comb begin
        cls = COMMON;
        if (opcode == OP_OP || opcode == OP_IMM ||
            opcode == OP_LUI || opcode == OP_AUIPC) begin
            cls = ALU;
        end
    end

    assign writes_rd = (opcode != OP_STORE) && (opcode != OP_BRANCH);
endmodule

// File: rtl/dual_issue_dispatch.sv
// dual_issue_dispatch: D stage of the dual-issue RV32 core.
// Steers an in-order pair: memory/control (COMMON) to datapath-1, ALU-only to
// datapath-2, swapping when only the older is ALU and splitting over two
// cycles when both are COMMON. Owns the D registers of both datapaths.
// Ports: clk, rst (sync, active-high), fetch (pair handshake, slave),
// stall_d, flush_d, instr_d/pc_d/valid_d (DP1), instr_d_2/pc_d_2/valid_d_2
// (DP2), order_change_d (DP2 holds the older instr), rdd/rdd_2 (dest regs,
// 0 when slot empty), dbg_state (dispatch FSM state).
// Build option: PAIR_RAW_SPLIT_EN also splits pairs where the younger
// instruction reads the older one's destination register.
module dual_issue_dispatch
    import dispatch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    dual_issue_dispatch_if.slave      fetch,
    input  logic                      stall_d,
    input  logic                      flush_d,
    output logic [31:0]               instr_d,
    output logic [31:0]               pc_d,
    output logic                      valid_d,
    output logic [31:0]               instr_d_2,
    output logic [31:0]               pc_d_2,
    output logic                      valid_d_2,
    output logic                      order_change_d,
    output logic [4:0]                rdd,
    output logic [4:0]                rdd_2,
    output dispatch_state_t           dbg_state
);
    instr_class_t    o_cls, y_cls;
    logic [4:0]      o_rd, o_rs1, o_rs2, y_rd, y_rs1, y_rs2;
    logic            o_writes, y_writes;
    logic            split_need;
    logic            unused_fields;

    d_slot_t         slot1_q, slot2_q, nxt1, nxt2, slot_o, slot_y;
    logic            oc_q, nxt_oc;
    dispatch_state_t state_q, nxt_state;

    instr_classifier u_cls_o (
        .instr(fetch.instr0_f), .cls(o_cls), .rd(o_rd),
        .rs1(o_rs1), .rs2(o_rs2), .writes_rd(o_writes)
    );

    instr_classifier u_cls_y (
        .instr(fetch.instr1_f), .cls(y_cls), .rd(y_rd),
        .rs1(y_rs1), .rs2(y_rs2), .writes_rd(y_writes)
    );

    assign unused_fields = ^{o_rd, o_rs1, o_rs2, o_writes, y_rd, y_rs1, y_rs2, y_writes};

`ifdef PAIR_RAW_SPLIT_EN
    logic raw_dep;
    assign raw_dep    = o_writes && (o_rd != 5'd0) && ((y_rs1 == o_rd) || (y_rs2 == o_rd));
    assign split_need = ((o_cls == COMMON) && (y_cls == COMMON)) || raw_dep;
`else
    assign split_need = (o_cls == COMMON) && (y_cls == COMMON);
`endif

    // In HOLD the younger instruction is read straight from fetch, which is
    // held stable because the pair was not yet accepted.
    assign fetch.fetch_ready = !rst && !flush_d && !stall_d && fetch.fetch_valid &&
                               ((state_q == HOLD) || !split_need);

    always_comb begin
        slot_o.instr = fetch.instr0_f;
        slot_o.pc    = fetch.pc0_f;
        slot_o.valid = 1'b1;
        slot_y.instr = fetch.instr1_f;
        slot_y.pc    = fetch.pc0_f + 32'd4;
        slot_y.valid = 1'b1;

        nxt1      = bubble_slot();
        nxt2      = bubble_slot();
        nxt_oc    = 1'b0;
        nxt_state = state_q;

        case (state_q)
            PAIR: begin
                if (fetch.fetch_valid) begin
                    if (split_need) begin
                        // Older goes alone into the slot its class belongs to.
                        nxt_state = HOLD;
                        if (o_cls == ALU) nxt2 = slot_o;
                        else              nxt1 = slot_o;
                    end else if (o_cls == ALU && y_cls == COMMON) begin
                        nxt1   = slot_y;
                        nxt2   = slot_o;
                        nxt_oc = 1'b1;
                    end else begin
                        nxt1 = slot_o;
                        nxt2 = slot_y;
                    end
                end
            end
            HOLD: begin
                if (fetch.fetch_valid) begin
                    nxt1      = slot_y;
                    nxt_state = PAIR;
                end
            end
            default: nxt_state = PAIR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            slot1_q <= bubble_slot();
            slot2_q <= bubble_slot();
            oc_q    <= 1'b0;
            state_q <= PAIR;
        end else if (!stall_d) begin
            slot1_q <= nxt1;
            slot2_q <= nxt2;
            oc_q    <= nxt_oc;
            state_q <= nxt_state;
        end
    end

    assign instr_d        = slot1_q.instr;
    assign pc_d           = slot1_q.pc;
    assign valid_d        = slot1_q.valid;
    assign instr_d_2      = slot2_q.instr;
    assign pc_d_2         = slot2_q.pc;
    assign valid_d_2      = slot2_q.valid;
    assign order_change_d = oc_q;
    assign rdd            = slot1_q.valid ? slot1_q.instr[11:7] : 5'd0;
    assign rdd_2          = slot2_q.valid ? slot2_q.instr[11:7] : 5'd0;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_dual_issue_dispatch.sv
module tb_dual_issue_dispatch;
    import dispatch_pkg::*;

    localparam logic [31:0] I_ADDI1  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD2   = 32'h0041_8133; // add x2,x3,x4
    localparam logic [31:0] I_ADD5   = 32'h0073_02B3; // add x5,x6,x7
    localparam logic [31:0] I_LW8    = 32'h0004_A403; // lw x8,0(x9)
    localparam logic [31:0] I_LW1    = 32'h0001_2083; // lw x1,0(x2)
    localparam logic [31:0] I_SW2    = 32'h0021_A023; // sw x2,0(x3)
    localparam logic [31:0] I_ADDI3  = 32'h0010_0193; // addi x3,x0,1
    localparam logic [31:0] I_ADD4   = 32'h0031_8233; // add x4,x3,x3
    localparam logic [31:0] I_LUI10  = 32'h1234_5537; // lui x10,0x12345
    localparam logic [31:0] I_JAL1   = 32'h0080_00EF; // jal x1,8
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst, stall_d, flush_d;
    logic [31:0] instr_d, pc_d, instr_d_2, pc_d_2;
    logic valid_d, valid_d_2, order_change_d;
    logic [4:0] rdd, rdd_2;
    dispatch_state_t dbg_state;

    dual_issue_dispatch_if fetch ();

    dual_issue_dispatch dut (
        .clk(clk), .rst(rst), .fetch(fetch), .stall_d(stall_d), .flush_d(flush_d),
        .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .instr_d_2(instr_d_2), .pc_d_2(pc_d_2), .valid_d_2(valid_d_2),
        .order_change_d(order_change_d), .rdd(rdd), .rdd_2(rdd_2),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;
    logic [141:0] exp_q[$];

    function automatic logic [141:0] pk(input logic [31:0] i1, input logic [31:0] p1,
                                        input logic [31:0] i2, input logic [31:0] p2,
                                        input logic v1, input logic v2, input logic oc,
                                        input logic [4:0] r1, input logic [4:0] r2,
                                        input logic st);
        return {i1, p1, i2, p2, v1, v2, oc, r1, r2, st};
    endfunction

    function automatic logic [141:0] actual();
        return {instr_d, pc_d, instr_d_2, pc_d_2, valid_d, valid_d_2, order_change_d,
                rdd, rdd_2, dbg_state};
    endfunction

    typedef struct {
        logic [31:0]  i0;
        logic [31:0]  i1;
        logic [31:0]  pc0;
        logic [141:0] exp;
    } vec_t;

    vec_t vecs[5];
    logic [141:0] idle_exp;

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p);
        fetch.fetch_valid = v;
        fetch.instr0_f    = a;
        fetch.instr1_f    = b;
        fetch.pc0_f       = p;
        #1;
    endtask

    task automatic check_ready(input string name, input logic exp);
        tests++;
        if (fetch.fetch_ready !== exp) begin
            errors++;
            $display("FAIL %s fetch_ready got=%b exp=%b", name, fetch.fetch_ready, exp);
        end
    endtask

    task automatic tick(input string name);
        logic [141:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (actual() !== e) begin
                errors++;
                $display("FAIL %s d_regs got=%h exp=%h", name, actual(), e);
            end
        end
    endtask

    initial begin
        idle_exp = pk(NOP, 32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, PAIR);
        vecs[0] = '{I_ADDI1, I_ADD2, 32'h100,
                    pk(I_ADDI1, 32'h100, I_ADD2, 32'h104, 1, 1, 0, 5'd1, 5'd2, PAIR)};
        vecs[1] = '{I_ADD5, I_LW8, 32'h200,
                    pk(I_LW8, 32'h204, I_ADD5, 32'h200, 1, 1, 1, 5'd8, 5'd5, PAIR)};
        vecs[2] = '{I_JAL1, I_LUI10, 32'h300,
                    pk(I_JAL1, 32'h300, I_LUI10, 32'h304, 1, 1, 0, 5'd1, 5'd10, PAIR)};
        vecs[3] = '{I_LUI10, I_ADDI1, 32'hFFFF_FFFC,
                    pk(I_LUI10, 32'hFFFF_FFFC, I_ADDI1, 32'h0, 1, 1, 0, 5'd10, 5'd1, PAIR)};
        vecs[4] = '{I_ADDI1, I_SW2, 32'h400,
                    pk(I_SW2, 32'h404, I_ADDI1, 32'h400, 1, 1, 1, 5'd0, 5'd1, PAIR)};

        // clock/reset
        rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check_ready("ready_in_reset", 1'b0);
        exp_q.push_back(idle_exp);
        tick("reset_values");
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check_ready("ready_no_fetch", 1'b0);
        exp_q.push_back(idle_exp);
        tick("idle_bubble");

        // table of single-cycle pairs
        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].i0, vecs[k].i1, vecs[k].pc0);
            check_ready($sformatf("vec%0d_ready", k), 1'b1);
            exp_q.push_back(vecs[k].exp);
            tick($sformatf("vec%0d", k));
        end

        // fetch goes idle: bubbles in both slots
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(idle_exp);
        tick("no_fetch_bubble");

        // split: lw then sw
        drive(1'b1, I_LW1, I_SW2, 32'h500);
        check_ready("split_c1_ready", 1'b0);
        exp_q.push_back(pk(I_LW1, 32'h500, NOP, 32'h0, 1, 0, 0, 5'd1, 5'd0, HOLD));
        tick("split_c1");
        check_ready("split_c2_ready", 1'b1);
        exp_q.push_back(pk(I_SW2, 32'h504, NOP, 32'h0, 1, 0, 0, 5'd0, 5'd0, PAIR));
        tick("split_c2");

        // stall in HOLD, then flush (with stall still high)
        drive(1'b1, I_LW1, I_SW2, 32'h600);
        exp_q.push_back(pk(I_LW1, 32'h600, NOP, 32'h0, 1, 0, 0, 5'd1, 5'd0, HOLD));
        tick("hold_enter");
        stall_d = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            check_ready($sformatf("stall%0d_ready", s), 1'b0);
            exp_q.push_back(pk(I_LW1, 32'h600, NOP, 32'h0, 1, 0, 0, 5'd1, 5'd0, HOLD));
            tick($sformatf("stall%0d_hold", s));
        end
        flush_d = 1'b1;
        #1;
        check_ready("flush_ready", 1'b0);
        exp_q.push_back(idle_exp);
        tick("flush_bubble");
        flush_d = 1'b0; stall_d = 1'b0;
        #1;
        check_ready("replay_c1_ready", 1'b0);
        exp_q.push_back(pk(I_LW1, 32'h600, NOP, 32'h0, 1, 0, 0, 5'd1, 5'd0, HOLD));
        tick("replay_c1");
        check_ready("replay_c2_ready", 1'b1);
        exp_q.push_back(pk(I_SW2, 32'h604, NOP, 32'h0, 1, 0, 0, 5'd0, 5'd0, PAIR));
        tick("replay_c2");

        // intra-pair RAW dependency
        drive(1'b1, I_ADDI3, I_ADD4, 32'h700);
`ifdef PAIR_RAW_SPLIT_EN
        check_ready("raw_c1_ready", 1'b0);
        exp_q.push_back(pk(NOP, 32'h0, I_ADDI3, 32'h700, 0, 1, 0, 5'd0, 5'd3, HOLD));
        tick("raw_c1");
        check_ready("raw_c2_ready", 1'b1);
        exp_q.push_back(pk(I_ADD4, 32'h704, NOP, 32'h0, 1, 0, 0, 5'd4, 5'd0, PAIR));
        tick("raw_c2");
`else
        check_ready("raw_ready", 1'b1);
        exp_q.push_back(pk(I_ADDI3, 32'h700, I_ADD4, 32'h704, 1, 1, 0, 5'd3, 5'd4, PAIR));
        tick("raw_pair");
`endif

        // reset in HOLD
        drive(1'b1, I_LW1, I_SW2, 32'h800);
        exp_q.push_back(pk(I_LW1, 32'h800, NOP, 32'h0, 1, 0, 0, 5'd1, 5'd0, HOLD));
        tick("rst_hold_enter");
        rst = 1'b1;
        #1;
        check_ready("rst_hold_ready", 1'b0);
        exp_q.push_back(idle_exp);
        tick("rst_in_hold");
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
